snitch_icache_refill_ctrl: RTL

Miss-side counterpart of the serial L1 instruction-cache lookup. It accepts lookup misses, fetches the missing line from the refill port, and drives the lookup stage's write interface (line index, set, data, tag, error). It then returns the line to the requesting fetch ports. One line is outstanding at a time; misses to the same line coalesce into that outstanding refill.

---
 rtl/snitch_icache_pkg.sv | 37 +++
 rtl/snitch_icache_refill_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache configuration type and a helper that derives the
// dependent alignment fields from the primary geometry.
package snitch_icache_pkg;

  typedef struct packed {
    int unsigned FETCH_AW;
    int unsigned LINE_ALIGN;
    int unsigned COUNT_ALIGN;
    int unsigned SET_ALIGN;
    int unsigned SET_COUNT;
    int unsigned TAG_WIDTH;
    int unsigned LINE_WIDTH;
    int unsigned ID_WIDTH_REQ;
  } config_t;

  // Derives LINE_ALIGN, SET_ALIGN and TAG_WIDTH so callers cannot pick
  // inconsistent values.
  function automatic config_t make_cfg(input int unsigned fetch_aw,
                                       input int unsigned line_width,
                                       input int unsigned set_count,
                                       input int unsigned count_align,
                                       input int unsigned id_width);
    config_t c;
    c.FETCH_AW     = fetch_aw;
    c.LINE_WIDTH   = line_width;
    c.LINE_ALIGN   = $clog2(line_width / 8);
    c.COUNT_ALIGN  = count_align;
    c.SET_COUNT    = set_count;
    c.SET_ALIGN    = (set_count > 1) ? $clog2(set_count) : 1;
    c.TAG_WIDTH    = fetch_aw - c.LINE_ALIGN - count_align;
    c.ID_WIDTH_REQ = id_width;
    return c;
  endfunction

  localparam config_t DefaultCfg = make_cfg(32, 128, 4, 3, 4);

endpackage

// File: rtl/snitch_icache_refill_ctrl.sv
// Miss handler for the serial L1 instruction cache: refills one line at a
// time, writes it into the lookup stage and answers all coalesced requesters.
module snitch_icache_refill_ctrl
  import snitch_icache_pkg::*;
#(
  parameter config_t CFG = DefaultCfg
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,

  input  logic                        flush_valid_i,
  output logic                        flush_ready_o,

  input  logic [CFG.FETCH_AW-1:0]     miss_addr_i,
  input  logic [CFG.ID_WIDTH_REQ-1:0] miss_id_i,
  input  logic                        miss_valid_i,
  output logic                        miss_ready_o,

  output logic [CFG.FETCH_AW-1:0]     refill_req_addr_o,
  output logic                        refill_req_valid_o,
  input  logic                        refill_req_ready_i,

  input  logic [CFG.LINE_WIDTH-1:0]   refill_rsp_data_i,
  input  logic                        refill_rsp_error_i,
  input  logic                        refill_rsp_valid_i,
  output logic                        refill_rsp_ready_o,

  output logic [CFG.COUNT_ALIGN-1:0]  write_addr_o,
  output logic [CFG.SET_ALIGN-1:0]    write_set_o,
  output logic [CFG.LINE_WIDTH-1:0]   write_data_o,
  output logic [CFG.TAG_WIDTH-1:0]    write_tag_o,
  output logic                        write_error_o,
  output logic                        write_valid_o,
  input  logic                        write_ready_i,

  output logic [CFG.LINE_WIDTH-1:0]   rsp_data_o,
  output logic                        rsp_error_o,
  output logic [CFG.ID_WIDTH_REQ-1:0] rsp_id_o,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i
);

  localparam int unsigned FetchAw    = CFG.FETCH_AW;
  localparam int unsigned LineAlign  = CFG.LINE_ALIGN;
  localparam int unsigned CountAlign = CFG.COUNT_ALIGN;
  localparam int unsigned SetAlign   = CFG.SET_ALIGN;
  localparam int unsigned SetCount   = CFG.SET_COUNT;

  localparam logic [FetchAw-1:0] LineMask =
    {{(FetchAw - LineAlign){1'b1}}, {LineAlign{1'b0}}};

  typedef enum logic [2:0] {
    Idle,
    ReqRefill,
    WaitRsp,
    WriteLine,
    Respond
  } state_e;

  state_e                        state_q, state_d;
  logic [FetchAw-1:0]            line_q, line_d;
  logic [CFG.ID_WIDTH_REQ-1:0]   id_q, id_d;
  logic [SetAlign-1:0]           set_q, set_d;
  logic [SetAlign-1:0]           victim_q, victim_d;
  logic [CFG.LINE_WIDTH-1:0]     data_q, data_d;
  logic                          error_q, error_d;

  logic                          same_line;
  logic                          miss_ready;
  logic                          flush_ready;
  logic [SetAlign-1:0]           victim_inc;

  assign same_line = ((miss_addr_i ^ line_q) & LineMask) == '0;

  always_comb begin
    if (SetCount <= 1) begin
      victim_inc = '0;
    end else if (victim_q == SetAlign'(SetCount - 1)) begin
      victim_inc = '0;
    end else begin
      victim_inc = victim_q + SetAlign'(1);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d            = state_q;
    line_d             = line_q;
    id_d               = id_q;
    set_d              = set_q;
    victim_d           = victim_q;
    data_d             = data_q;
    error_d            = error_q;
    miss_ready         = 1'b0;
    flush_ready        = 1'b0;
    refill_req_valid_o = 1'b0;
    refill_rsp_ready_o = 1'b0;
    write_valid_o      = 1'b0;
    rsp_valid_o        = 1'b0;

    unique case (state_q)
      Idle: begin
        flush_ready = 1'b1;
        miss_ready  = ~flush_valid_i;
        if (flush_valid_i) begin
          victim_d = '0;
        end else if (miss_valid_i) begin
          line_d   = miss_addr_i & LineMask;
          id_d     = miss_id_i;
          set_d    = victim_q;
          victim_d = victim_inc;
          state_d  = ReqRefill;
        end
      end
      ReqRefill: begin
        refill_req_valid_o = 1'b1;
        miss_ready         = same_line;
        if (miss_valid_i && same_line) id_d = id_q | miss_id_i;
        if (refill_req_ready_i) state_d = WaitRsp;
      end
      WaitRsp: begin
        refill_rsp_ready_o = 1'b1;
        miss_ready         = same_line;
        if (miss_valid_i && same_line) id_d = id_q | miss_id_i;
        if (refill_rsp_valid_i) begin
          data_d  = refill_rsp_data_i;
          error_d = refill_rsp_error_i;
          state_d = WriteLine;
        end
      end
      WriteLine: begin
        write_valid_o = 1'b1;
        if (write_ready_i) state_d = Respond;
      end
      Respond: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = Idle;
      end
      default: state_d = Idle;
    endcase
  end

  // Readies are held low while reset is asserted, even though the state reads Idle.
  assign miss_ready_o  = miss_ready & rst_ni;
  assign flush_ready_o = flush_ready & rst_ni;

  assign refill_req_addr_o = line_q;
  assign write_addr_o      = line_q[LineAlign +: CountAlign];
  assign write_tag_o       = line_q[FetchAw-1 : LineAlign + CountAlign];
  assign write_set_o       = set_q;
  assign write_data_o      = data_q;
  assign write_error_o     = error_q;
  assign rsp_data_o        = data_q;
  assign rsp_error_o       = error_q;
  assign rsp_id_o          = id_q;

  // NOTE: sequential state uses non-blocking assignments so all flops
  // update together from the pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= Idle;
      line_q   <= '0;
      id_q     <= '0;
      set_q    <= '0;
      victim_q <= '0;
      // NOTE: the line buffer is a single register, not a memory array, so it
      // is cheap to reset and keeps the payload outputs at zero out of reset.
      data_q   <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      id_q     <= id_d;
      set_q    <= set_d;
      victim_q <= victim_d;
      data_q   <= data_d;
      error_q  <= error_d;
    end
  end

endmodule
